// File: rtl/udp_vlg_tx_arb.sv
// udp_vlg_tx_arb: round-robin arbiter sharing one UDP TX path among N controllers, grant locked per datagram.
// Optional watchdog abort enabled by defining UDP_VLG_TX_ARB_TIMEOUT_EN.
module udp_vlg_tx_arb #(
  parameter int N = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        in_rdy,
  output logic [N-1:0]        in_req,
  input  logic [N-1:0][15:0]  in_src_port,
  input  logic [N-1:0][15:0]  in_dst_port,
  input  logic [N-1:0][15:0]  in_length,
  input  logic [N-1:0][31:0]  in_dst_ip,
  input  logic [N-1:0][7:0]   in_dat,
  input  logic [N-1:0]        in_sof,
  input  logic [N-1:0]        in_eof,
  input  logic [N-1:0]        in_val,
  output logic                out_rdy,
  input  logic                out_req,
  output logic [15:0]         out_src_port,
  output logic [15:0]         out_dst_port,
  output logic [15:0]         out_length,
  output logic [31:0]         out_dst_ip,
  output logic [7:0]          out_dat,
  output logic                out_sof,
  output logic                out_eof,
  output logic                out_val,
  output logic [N-1:0]        out_gnt,
  output logic                out_err
);
  localparam int W = $clog2(N);
  typedef enum logic [1:0] {IDLE, OFFER, XFER} state_t;
  state_t state;
  logic [W-1:0] ptr, g, sel, nxt;
  logic found, xfer, done, expire;
  int idx;
  always_comb begin
    found = 1'b0;
    sel = '0;
    idx = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      idx = idx >= N ? idx - N : idx;
      if (!found && in_rdy[idx]) begin
        found = 1'b1;
        sel = W'(idx);
      end
    end
  end
  assign nxt = int'(g) == N - 1 ? '0 : g + 1'b1;
  assign xfer = state == XFER;
  assign done = xfer && in_val[g] && in_eof[g];
  // requesters start their FIFO read in the same cycle as req
  assign in_req = out_req ? out_gnt : '0;
  assign out_dat = xfer ? in_dat[g] : '0;
  assign out_sof = xfer && in_sof[g];
  assign out_eof = xfer && in_eof[g];
  assign out_val = xfer && in_val[g];
`ifdef UDP_VLG_TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT) + 1;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else cnt <= (state == IDLE || (state == OFFER && out_req) || (xfer && in_val[g])) ? '0 : cnt + 1'b1;
  end
  assign expire = state != IDLE && cnt == CW'(TIMEOUT - 1);
`else
  assign expire = TIMEOUT < 0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      g <= '0;
      out_rdy <= 1'b0;
      out_gnt <= '0;
      out_err <= 1'b0;
      out_src_port <= '0;
      out_dst_port <= '0;
      out_length <= '0;
      out_dst_ip <= '0;
    end else begin
      out_err <= 1'b0;
      case (state)
        IDLE: if (found) begin
          g <= sel;
          out_gnt <= N'(1) << sel;
          out_rdy <= 1'b1;
          out_src_port <= in_src_port[sel];
          out_dst_port <= in_dst_port[sel];
          out_length <= in_length[sel];
          out_dst_ip <= in_dst_ip[sel];
          state <= OFFER;
        end
        OFFER: if (out_req) begin
          out_rdy <= 1'b0;
          state <= XFER;
        end else if (!in_rdy[g] || expire) begin
          out_rdy <= 1'b0;
          out_gnt <= '0;
          out_err <= in_rdy[g];
          ptr <= in_rdy[g] ? nxt : ptr;
          state <= IDLE;
        end
        XFER: if (done || expire) begin
          out_gnt <= '0;
          out_err <= !done;
          ptr <= nxt;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_udp_vlg_tx_arb.sv
// tb_udp_vlg_tx_arb: directed bench for udp_vlg_tx_arb with grant/byte scoreboards.
module tb_udp_vlg_tx_arb;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] in_rdy, in_req, in_sof, in_eof, in_val, out_gnt;
  logic [N-1:0][15:0] in_src_port, in_dst_port, in_length;
  logic [N-1:0][31:0] in_dst_ip;
  logic [N-1:0][7:0] in_dat;
  logic out_rdy, out_req, out_sof, out_eof, out_val, out_err;
  logic [15:0] out_src_port, out_dst_port, out_length;
  logic [31:0] out_dst_ip;
  logic [7:0] out_dat;
  int n_cmp = 0;
  int n_err = 0;
  int gq[$];
  logic [9:0] bq[$];
  always #5 clk = ~clk;
  udp_vlg_tx_arb #(.N(N), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_rdy(in_rdy), .in_req(in_req),
    .in_src_port(in_src_port), .in_dst_port(in_dst_port), .in_length(in_length),
    .in_dst_ip(in_dst_ip), .in_dat(in_dat), .in_sof(in_sof), .in_eof(in_eof),
    .in_val(in_val), .out_rdy(out_rdy), .out_req(out_req),
    .out_src_port(out_src_port), .out_dst_port(out_dst_port), .out_length(out_length),
    .out_dst_ip(out_dst_ip), .out_dat(out_dat), .out_sof(out_sof), .out_eof(out_eof),
    .out_val(out_val), .out_gnt(out_gnt), .out_err(out_err)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic check_hdr(input int i);
    chk("hdr_src", 64'(out_src_port), 64'(16'h1000 + 16'(i)));
    chk("hdr_dst", 64'(out_dst_port), 64'(16'h2000 + 16'(i)));
    chk("hdr_len", 64'(out_length), i == 0 ? 64'h0010 : 64'(16'h0020 + 16'(i)));
    chk("hdr_ip", 64'(out_dst_ip), 64'(32'h0A000001 + 32'(i) * 32'h100));
  endtask
  task automatic clear_stream();
    in_val = '0;
    in_sof = '0;
    in_eof = '0;
    in_dat = '0;
  endtask
  task automatic wait_offer();
    int k = 0;
    int e;
    while (!out_rdy && k < 8) begin
      tick();
      k++;
    end
    chk("offer", 64'(out_rdy), 64'd1);
    e = gq.size() > 0 ? gq.pop_front() : 0;
    chk("gnt", 64'(out_gnt), 64'(1) << e);
    check_hdr(e);
  endtask
  task automatic drive_byte(input int g, input int b, input int n, input logic [7:0] base);
    logic [9:0] e;
    in_val = '1;
    in_sof = '1;
    in_eof = '1;
    in_dat = {N{8'hEE}};
    in_dat[g] = 8'(base + 8'(b));
    in_sof[g] = b == 0;
    in_eof[g] = b == n - 1;
    bq.push_back({in_sof[g], in_eof[g], in_dat[g]});
    #1;
    chk("val", 64'(out_val), 64'd1);
    e = bq.pop_front();
    chk("stream", 64'({out_sof, out_eof, out_dat}), 64'(e));
  endtask
  task automatic xfer(input int g, input int n, input logic [7:0] base, input bit keep);
    out_req = 1'b1;
    #1;
    chk("in_req", 64'(in_req), 64'(1) << g);
    chk("offer_val", 64'(out_val), 64'd0);
    tick();
    out_req = 1'b0;
    if (!keep) in_rdy[g] = 1'b0;
    for (int b = 0; b < n; b++) begin
      drive_byte(g, b, n, base);
      tick();
    end
    clear_stream();
    #1;
    chk("rel_gnt", 64'(out_gnt), 64'd0);
    chk("rel_rdy", 64'(out_rdy), 64'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < N; i++) begin
      in_src_port[i] = 16'h1000 + 16'(i);
      in_dst_port[i] = 16'h2000 + 16'(i);
      in_length[i] = i == 0 ? 16'h0010 : 16'h0020 + 16'(i);
      in_dst_ip[i] = 32'h0A000001 + 32'(i) * 32'h100;
    end
    in_rdy = '0;
    out_req = 1'b0;
    clear_stream();
    repeat (3) tick();
    chk("rst_rdy", 64'(out_rdy), 64'd0);
    chk("rst_gnt", 64'(out_gnt), 64'd0);
    chk("rst_err", 64'(out_err), 64'd0);
    chk("rst_req", 64'(in_req), 64'd0);
    chk("rst_hdr", {out_src_port, out_dst_port, out_length}, 64'd0);
    chk("rst_ip", 64'(out_dst_ip), 64'd0);
    chk("rst_stream", 64'({out_val, out_sof, out_eof, out_dat}), 64'd0);
    rst_n = 1'b1;
    tick();
    in_rdy = 4'b0001;
    #1;
    chk("lat0", 64'(out_rdy), 64'd0);
    tick();
    chk("lat1", 64'(out_rdy), 64'd1);
    chk("lat_gnt", 64'(out_gnt), 64'b0001);
    check_hdr(0);
    xfer(0, 8, 8'h00, 1'b0);
    in_rdy = 4'b0011;
    gq.push_back(1);
    wait_offer();
    xfer(1, 2, 8'h40, 1'b0);
    in_rdy = 4'b0100;
    gq.push_back(2);
    wait_offer();
    xfer(2, 2, 8'h50, 1'b0);
    in_rdy = 4'b1001;
    gq.push_back(3);
    gq.push_back(0);
    wait_offer();
    xfer(3, 3, 8'h60, 1'b0);
    wait_offer();
    xfer(0, 2, 8'h70, 1'b0);
    in_rdy = 4'b0100;
    gq.push_back(2);
    wait_offer();
    chk("wd_noreq", 64'(in_req), 64'd0);
    in_rdy[2] = 1'b0;
    tick();
    chk("wd_rdy", 64'(out_rdy), 64'd0);
    chk("wd_gnt", 64'(out_gnt), 64'd0);
    chk("wd_inreq", 64'(in_req), 64'd0);
    in_rdy = 4'b1111;
    gq.push_back(1);
    wait_offer();
    xfer(1, 2, 8'h80, 1'b0);
    gq.push_back(2);
    wait_offer();
    out_req = 1'b1;
    tick();
    out_req = 1'b0;
    in_rdy[2] = 1'b0;
    drive_byte(2, 0, 8, 8'h90);
    tick();
    drive_byte(2, 1, 8, 8'h90);
    tick();
    drive_byte(2, 2, 8, 8'h90);
    rst_n = 1'b0;
    #1;
    chk("mrst_gnt", 64'(out_gnt), 64'd0);
    chk("mrst_rdy", 64'(out_rdy), 64'd0);
    chk("mrst_stream", 64'({out_val, out_sof, out_eof, out_dat}), 64'd0);
    chk("mrst_hdr", {out_src_port, out_dst_port, out_length}, 64'd0);
    clear_stream();
    in_rdy = 4'b1111;
    tick();
    chk("mrst_hold", 64'(out_rdy), 64'd0);
    rst_n = 1'b1;
    gq.push_back(0);
    wait_offer();
    in_rdy = '0;
    tick();
    chk("mrst_wd", 64'(out_gnt), 64'd0);
    in_rdy = 4'b1010;
    gq.push_back(1);
    gq.push_back(3);
    gq.push_back(1);
    wait_offer();
    xfer(1, 2, 8'hA0, 1'b1);
    wait_offer();
    xfer(3, 2, 8'hB0, 1'b1);
    wait_offer();
    xfer(1, 3, 8'hC0, 1'b1);
    in_rdy = 4'b0011;
    gq.push_back(0);
    wait_offer();
`ifdef UDP_VLG_TX_ARB_TIMEOUT_EN
    for (int k = 1; k < 16; k++) begin
      tick();
      chk("tmo_quiet", 64'(out_err), 64'd0);
    end
    tick();
    chk("tmo_err", 64'(out_err), 64'd1);
    chk("tmo_gnt", 64'(out_gnt), 64'd0);
    chk("tmo_rdy", 64'(out_rdy), 64'd0);
    gq.push_back(1);
    wait_offer();
    chk("tmo_pulse", 64'(out_err), 64'd0);
`else
    repeat (40) tick();
    chk("hold_rdy", 64'(out_rdy), 64'd1);
    chk("hold_gnt", 64'(out_gnt), 64'b0001);
    chk("hold_err", 64'(out_err), 64'd0);
`endif
    in_rdy = '0;
    tick();
    chk("end_gnt", 64'(out_gnt), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/udp_vlg_tx_arb.md
# udp_vlg_tx_arb

Round-robin arbiter sharing the single UDP transmit path (metadata plus byte stream, rdy/req handshake) among N UDP TX controllers. It sits between the per-port UDP TX controllers and the IPv4 TX stage. It grants one requester per datagram, presents that requester's header metadata, and muxes its stream. The grant is locked until the datagram's eof byte has been transferred.

## Interface
- N, 4: number of requesters (2..8).
- TIMEOUT, 4096: watchdog limit in cycles; only used when UDP_VLG_TX_ARB_TIMEOUT_EN is defined.
- clk  in  1  clock; one clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- in_rdy  in  N  requester i has a datagram pending.
- in_req  out  N  one-hot request back to the granted requester.
- in_src_port, in_dst_port, in_length  in  N×16 each  per-requester UDP header fields; in_length is the total UDP length.
- in_dst_ip  in  N×32  per-requester destination IPv4 address.
- in_dat  in  N×8  per-requester stream data.
- in_sof, in_eof, in_val  in  N each  per-requester stream flags.
- out_rdy  out  1  datagram offered downstream.
- out_req  in  1  downstream accepts the offered datagram.
- out_src_port, out_dst_port, out_length  out  16 each  latched header of the granted requester.
- out_dst_ip  out  32  latched destination IP.
- out_dat  out  8; out_sof, out_eof, out_val  out  1 each  muxed stream.
- out_gnt  out  N  one-hot current grant; 0 when idle.
- out_err  out  1  one-cycle watchdog abort pulse.

## Operation
- FSM states: IDLE, OFFER, XFER.
- **IDLE**
  - Scan in_rdy starting at pointer ptr and wrapping modulo N.
  - The first set bit g wins. Latch in_*[g] header fields into the out_* header registers, set out_gnt = 1<<g, set out_rdy = 1, go to OFFER.
  - If no in_rdy bit is set, stay in IDLE.
- **OFFER**
  - Hold out_rdy.
  - in_req[g] = out_req & out_gnt[g], combinational. This is required because requesters start their FIFO read in the same cycle as req.
  - On out_req: out_rdy ← 0, go to XFER.
  - If in_rdy[g] falls before out_req: withdraw the offer, out_rdy ← 0, out_gnt ← 0, go to IDLE; ptr is unchanged.
- **XFER**
  - out_dat, out_sof, out_eof and out_val are combinational muxes of requester g.
  - Non-granted streams are ignored.
  - On in_val[g] & in_eof[g]: ptr ← (g+1) mod N, out_gnt ← 0, go to IDLE.
- Header registers hold their value until the next grant. Stream outputs are 0 whenever out_gnt = 0.
- Simultaneous in_rdy bits are resolved by ptr order only.
- in_rdy changes on non-granted requesters never affect the current grant.

## Timing
- Reset values:
  - state = IDLE, ptr = 0.
  - out_rdy = 0, out_gnt = 0, out_err = 0.
  - All header outputs = 0.
  - in_req = 0; all stream outputs = 0.
- Latencies:
  - in_rdy sampled high in IDLE → out_rdy high on the next cycle (1-cycle latency).
  - out_req → in_req[g] in the same cycle (0 latency).
  - Stream path: combinational, 0 latency.
- Datagram spacing: the cycle after the eof transfer is IDLE. The next out_rdy rises no earlier than 2 cycles after eof.
- Reset mid-operation: rst_n low asynchronously clears all state. Any in-flight datagram is truncated, and downstream must discard it.

## Configuration
- UDP_VLG_TX_ARB_TIMEOUT_EN defined:
  - A counter runs in OFFER and XFER. It is cleared on each state entry and on each cycle with in_val[g] in XFER.
  - When it reaches TIMEOUT−1, out_err pulses for 1 cycle, the grant is released, ptr ← g+1, and the FSM goes to IDLE.
  - An aborted XFER drives no eof; downstream uses out_err to drop the frame.
- Not defined: no counter is implemented, out_err is tied to 0, and TIMEOUT is ignored.

## Test plan
- **Single requester:** in_rdy = 0001, in_length = 0x0010, dst_ip = 0x0A000001, 8-byte stream 0x00..0x07. Required: out_rdy 1 cycle later with matching header. With out_req, in_req = 0001 in the same cycle. out_dat follows the requester stream. After eof, ptr = 1.
- **Contention:** in_rdy = 1010 held, ptr = 0. Required grant order is 0010, 1000, 0010, with each grant released only after its eof.
- **Fairness wrap:** ptr = 3 and in_rdy = 1001. Required: requester 3 granted first, then requester 0.
- **Withdraw:** in_rdy[2] drops during OFFER. Required: out_rdy = 0 next cycle, out_gnt = 0, ptr unchanged, no in_req issued.
- **Reset mid-XFER:** rst_n low on byte 3 of 8. Required: all outputs 0 immediately; after release, out_rdy re-offers from ptr = 0.
- **Watchdog (macro on, TIMEOUT = 16):** out_req never asserted. Required: out_err pulses 16 cycles after entering OFFER, grant releases, next requester is served. With the macro off, OFFER holds indefinitely.
